// File: rtl/fft_frame_sequencer.sv
// -----------------------------------------------------------------------------
// fft_frame_sequencer
//
// Frame-level controller for a radix-2 DIT FFT core. It collects N_POINTS input
// samples over a valid/ready handshake and gates each one into the core. It then
// pulses core_start and counts one core_stage_done pulse per butterfly stage.
// Finally it drains N_POINTS results to the sink, honouring output backpressure.
//
// Ports
//   clk             in   system clock, rising edge
//   reset           in   asynchronous, active-low reset
//   s_valid/s_ready in/out  input sample handshake (data travels on core inputs)
//   m_valid/m_ready out/in  output sample handshake (data travels on core outputs)
//   core_in_en      out  core captures the input sample this cycle
//   core_start      out  one-cycle pulse that starts the butterfly computation
//   core_out_en     out  core advances its output pointer this cycle
//   core_stage_done in   one-cycle pulse per completed stage
//   core_out_flag   in   core output data valid
//   core_overflow   in   arithmetic overflow in the current stage
//   busy            out  high in every state except IDLE
//   fft_done        out  one-cycle pulse on entry to IDLE after the last output
//   err_ovf         out  sticky overflow flag, cleared by next frame's first accept
//   frame_cnt       out  completed frames, wraps 255 -> 0
//   err_timeout     out  (FFT_SEQ_WATCHDOG_EN only) sticky watchdog timeout flag
//
// Optional feature: define FFT_SEQ_WATCHDOG_EN to add a COMPUTE watchdog.
// If no stage_done pulse arrives for TIMEOUT cycles, the sequencer parks in ERR.
// ERR is left only through reset.
// -----------------------------------------------------------------------------
module fft_frame_sequencer #(
   parameter int N_POINTS = 8,
   parameter int STAGES   = 3,
   parameter int TIMEOUT  = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       s_valid,
   output logic       s_ready,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       core_in_en,
   output logic       core_start,
   output logic       core_out_en,
   input  logic       core_stage_done,
   input  logic       core_out_flag,
   input  logic       core_overflow,
   output logic       busy,
   output logic       fft_done,
   output logic       err_ovf,
   output logic [7:0] frame_cnt
`ifdef FFT_SEQ_WATCHDOG_EN
   ,
   output logic       err_timeout
`endif
);

   localparam int CNT_W = $clog2(N_POINTS) + 1;
   localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(N_POINTS);
   localparam logic [CNT_W-1:0] LAST_STAGE  = CNT_W'(STAGES);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LOAD    = 3'd1;
   localparam logic [2:0] ST_KICK    = 3'd2;
   localparam logic [2:0] ST_COMPUTE = 3'd3;
   localparam logic [2:0] ST_DRAIN   = 3'd4;
`ifdef FFT_SEQ_WATCHDOG_EN
   localparam logic [2:0] ST_ERR     = 3'd5;
   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
`endif

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
   logic [CNT_W-1:0] stage_cnt_q, stage_cnt_d;
   logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
   logic             fft_done_q, fft_done_d;
   logic             err_ovf_q, err_ovf_d;
   logic [7:0]       frame_cnt_q, frame_cnt_d;
`ifdef FFT_SEQ_WATCHDOG_EN
   logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
   logic             err_timeout_q, err_timeout_d;
`endif

   logic accept;
   logic out_hs;

   // s_ready is gated by reset so it reads 0 while reset is held, even though
   // the state register already sits at IDLE.
   assign s_ready     = reset & ((state_q == ST_IDLE) | (state_q == ST_LOAD));
   assign core_in_en  = s_valid & s_ready;
   assign accept      = core_in_en;
   assign core_start  = (state_q == ST_KICK);
   assign core_out_en = (state_q == ST_DRAIN) & m_ready;
   assign m_valid     = (state_q == ST_DRAIN) & core_out_flag;
   assign out_hs      = m_valid & m_ready;
   assign busy        = (state_q != ST_IDLE);
   assign fft_done    = fft_done_q;
   assign err_ovf     = err_ovf_q;
   assign frame_cnt   = frame_cnt_q;
`ifdef FFT_SEQ_WATCHDOG_EN
   assign err_timeout = err_timeout_q;
`endif

   always_comb begin
      state_d     = state_q;
      in_cnt_d    = in_cnt_q;
      stage_cnt_d = stage_cnt_q;
      out_cnt_d   = out_cnt_q;
      fft_done_d  = 1'b0;
      err_ovf_d   = err_ovf_q;
      frame_cnt_d = frame_cnt_q;
`ifdef FFT_SEQ_WATCHDOG_EN
      wd_cnt_d      = wd_cnt_q;
      err_timeout_d = err_timeout_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               // The first accepted sample opens a new frame and clears the
               // overflow flag left over from the previous frame.
               state_d   = ST_LOAD;
               in_cnt_d  = CNT_W'(1);
               err_ovf_d = 1'b0;
            end
         end
         ST_LOAD: begin
            if (accept) begin
               if (in_cnt_q + 1'b1 == LAST_SAMPLE) begin
                  state_d  = ST_KICK;
                  in_cnt_d = '0;
               end else begin
                  in_cnt_d = in_cnt_q + 1'b1;
               end
            end
         end
         ST_KICK: begin
            stage_cnt_d = '0;
            state_d     = ST_COMPUTE;
`ifdef FFT_SEQ_WATCHDOG_EN
            wd_cnt_d    = '0;
`endif
         end
         ST_COMPUTE: begin
            if (core_overflow) begin
               err_ovf_d = 1'b1;
            end
            if (core_stage_done) begin
               if (stage_cnt_q + 1'b1 == LAST_STAGE) begin
                  state_d     = ST_DRAIN;
                  stage_cnt_d = '0;
                  out_cnt_d   = '0;
               end else begin
                  stage_cnt_d = stage_cnt_q + 1'b1;
               end
            end
`ifdef FFT_SEQ_WATCHDOG_EN
            // The watchdog reloads on every stage pulse. TIMEOUT silent cycles
            // in a row park the sequencer in ERR.
            if (core_stage_done) begin
               wd_cnt_d = '0;
            end else if (wd_cnt_q == WD_LAST) begin
               state_d       = ST_ERR;
               err_timeout_d = 1'b1;
            end else begin
               wd_cnt_d = wd_cnt_q + 1'b1;
            end
`endif
         end
         ST_DRAIN: begin
            if (out_hs) begin
               if (out_cnt_q + 1'b1 == LAST_SAMPLE) begin
                  state_d     = ST_IDLE;
                  out_cnt_d   = '0;
                  fft_done_d  = 1'b1;
                  frame_cnt_d = frame_cnt_q + 8'd1;
               end else begin
                  out_cnt_d = out_cnt_q + 1'b1;
               end
            end
         end
`ifdef FFT_SEQ_WATCHDOG_EN
         ST_ERR: begin
            state_d = ST_ERR;
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         in_cnt_q    <= '0;
         stage_cnt_q <= '0;
         out_cnt_q   <= '0;
         fft_done_q  <= 1'b0;
         err_ovf_q   <= 1'b0;
         frame_cnt_q <= 8'd0;
`ifdef FFT_SEQ_WATCHDOG_EN
         wd_cnt_q      <= '0;
         err_timeout_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         in_cnt_q    <= in_cnt_d;
         stage_cnt_q <= stage_cnt_d;
         out_cnt_q   <= out_cnt_d;
         fft_done_q  <= fft_done_d;
         err_ovf_q   <= err_ovf_d;
         frame_cnt_q <= frame_cnt_d;
`ifdef FFT_SEQ_WATCHDOG_EN
         wd_cnt_q      <= wd_cnt_d;
         err_timeout_q <= err_timeout_d;
`endif
      end
   end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fft_frame_sequencer
//
// Directed bench for fft_frame_sequencer. It covers reset state, a back-to-back
// frame, a gapped frame with output backpressure and overflow, the async reset
// mid-frame and the frame counter wrap. The watchdog is exercised when
// FFT_SEQ_WATCHDOG_EN is defined.
// -----------------------------------------------------------------------------
module tb_fft_frame_sequencer;

   logic       clk;
   logic       reset;
   logic       s_valid;
   logic       s_ready;
   logic       m_valid;
   logic       m_ready;
   logic       core_in_en;
   logic       core_start;
   logic       core_out_en;
   logic       core_stage_done;
   logic       core_out_flag;
   logic       core_overflow;
   logic       busy;
   logic       fft_done;
   logic       err_ovf;
   logic [7:0] frame_cnt;
`ifdef FFT_SEQ_WATCHDOG_EN
   logic       err_timeout;
`endif

   int vectors;
   int miscompares;
   int n_in;
   int n_out;

   fft_frame_sequencer #(
      .N_POINTS(8),
      .STAGES  (3),
      .TIMEOUT (64)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .s_valid         (s_valid),
      .s_ready         (s_ready),
      .m_valid         (m_valid),
      .m_ready         (m_ready),
      .core_in_en      (core_in_en),
      .core_start      (core_start),
      .core_out_en     (core_out_en),
      .core_stage_done (core_stage_done),
      .core_out_flag   (core_out_flag),
      .core_overflow   (core_overflow),
      .busy            (busy),
      .fft_done        (fft_done),
      .err_ovf         (err_ovf),
      .frame_cnt       (frame_cnt)
`ifdef FFT_SEQ_WATCHDOG_EN
      ,
      .err_timeout     (err_timeout)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One clean frame: 8 back-to-back inputs, 3 stage pulses, 8 outputs.
   task automatic run_frame();
      s_valid = 1'b1;
      repeat (8) tick();
      s_valid = 1'b0;
      tick();
      core_stage_done = 1'b1;
      repeat (3) tick();
      core_stage_done = 1'b0;
      m_ready       = 1'b1;
      core_out_flag = 1'b1;
      repeat (8) tick();
      m_ready       = 1'b0;
      core_out_flag = 1'b0;
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      vectors         = 0;
      miscompares     = 0;
      reset           = 1'b0;
      s_valid         = 1'b0;
      m_ready         = 1'b0;
      core_stage_done = 1'b0;
      core_out_flag   = 1'b0;
      core_overflow   = 1'b0;

      // Reset state
      #2;
      chk("rst_s_ready",   8'(s_ready),    8'd0);
      chk("rst_busy",      8'(busy),       8'd0);
      chk("rst_start",     8'(core_start), 8'd0);
      chk("rst_fft_done",  8'(fft_done),   8'd0);
      chk("rst_err_ovf",   8'(err_ovf),    8'd0);
      chk("rst_frame_cnt", frame_cnt,      8'd0);
      tick();
      tick();
      reset = 1'b1;
      #2;
      chk("idle_s_ready", 8'(s_ready), 8'd1);

      // Frame 1: 8 back-to-back samples
      n_in = 0;
      for (int i = 0; i < 8; i++) begin
         s_valid = 1'b1;
         #2;
         n_in += int'(core_in_en);
         tick();
      end
      chk("f1_n_in", 8'(n_in), 8'd8);
      #2;
      chk("kick_s_ready", 8'(s_ready),    8'd0);
      chk("kick_in_en",   8'(core_in_en), 8'd0);
      chk("kick_start",   8'(core_start), 8'd1);
      chk("kick_busy",    8'(busy),       8'd1);
      tick();
      chk("comp_start", 8'(core_start), 8'd0);
      s_valid = 1'b0;

      for (int k = 0; k < 3; k++) begin
         core_stage_done = 1'b1;
         tick();
         core_stage_done = 1'b0;
         tick();
      end
      #2;
      chk("drain_no_flag", 8'(m_valid), 8'd0);
      m_ready       = 1'b1;
      core_out_flag = 1'b1;
      n_out = 0;
      for (int i = 0; i < 8; i++) begin
         #2;
         n_out += int'(m_valid & m_ready & core_out_en);
         tick();
      end
      chk("f1_n_out",     8'(n_out),    8'd8);
      chk("f1_fft_done",  8'(fft_done), 8'd1);
      chk("f1_busy",      8'(busy),     8'd0);
      chk("f1_frame_cnt", frame_cnt,    8'd1);
      m_ready = 1'b0;
      tick();
      chk("f1_done_pulse", 8'(fft_done), 8'd0);
      chk("idle_m_valid",  8'(m_valid),  8'd0);
      core_out_flag   = 1'b0;
      core_stage_done = 1'b1;
      tick();
      core_stage_done = 1'b0;
      chk("idle_stage_ignored", 8'(busy), 8'd0);

      // Frame 2: gapped input, overflow coincident with stage 2, toggling m_ready
      n_in = 0;
      for (int i = 0; i < 16; i++) begin
         s_valid = (i % 2 == 0);
         #2;
         if (i == 15) chk("f2_kick_start", 8'(core_start), 8'd1);
         n_in += int'(core_in_en);
         tick();
      end
      chk("f2_n_in", 8'(n_in), 8'd8);
      s_valid = 1'b1;
      core_stage_done = 1'b1;
      tick();
      core_stage_done = 1'b0;
      tick();
      core_stage_done = 1'b1;
      core_overflow   = 1'b1;
      tick();
      core_stage_done = 1'b0;
      core_overflow   = 1'b0;
      chk("f2_err_ovf_set",  8'(err_ovf),    8'd1);
      chk("f2_comp_s_ready", 8'(s_ready),    8'd0);
      chk("f2_comp_in_en",   8'(core_in_en), 8'd0);
      chk("f2_still_busy",   8'(busy),       8'd1);
      core_stage_done = 1'b1;
      tick();
      core_stage_done = 1'b0;
      s_valid = 1'b0;
      n_out = 0;
      core_out_flag = 1'b1;
      for (int i = 0; i < 16; i++) begin
         m_ready = (i % 2 == 1);
         #2;
         n_out += int'(m_valid & m_ready);
         tick();
      end
      chk("f2_n_out",     8'(n_out),    8'd8);
      chk("f2_fft_done",  8'(fft_done), 8'd1);
      chk("f2_frame_cnt", frame_cnt,    8'd2);
      chk("f2_err_ovf",   8'(err_ovf),  8'd1);
      m_ready       = 1'b0;
      core_out_flag = 1'b0;
      tick();

      // Frame 3: err_ovf clears on first accept; reset mid-COMPUTE
      s_valid = 1'b1;
      #2;
      chk("f3_ovf_before", 8'(err_ovf), 8'd1);
      tick();
      chk("f3_ovf_cleared", 8'(err_ovf), 8'd0);
      repeat (7) tick();
      s_valid = 1'b0;
      tick();
      core_overflow = 1'b1;
      tick();
      core_overflow = 1'b0;
      chk("f3_ovf_set",    8'(err_ovf), 8'd1);
      chk("f3_frame_cnt",  frame_cnt,   8'd2);
      #2;
      reset = 1'b0;
      #1;
      chk("midrst_busy",      8'(busy),       8'd0);
      chk("midrst_err_ovf",   8'(err_ovf),    8'd0);
      chk("midrst_frame_cnt", frame_cnt,      8'd0);
      chk("midrst_s_ready",   8'(s_ready),    8'd0);
      chk("midrst_start",     8'(core_start), 8'd0);
      tick();
      reset = 1'b1;
      #2;
      chk("postrst_s_ready", 8'(s_ready), 8'd1);
      tick();

      // Frame counter wrap
      repeat (255) run_frame();
      chk("wrap_255", frame_cnt, 8'd255);
      run_frame();
      chk("wrap_0", frame_cnt, 8'd0);

`ifdef FFT_SEQ_WATCHDOG_EN
      // Watchdog: a stage pulse reloads the counter, then 64 silent cycles trip ERR
      s_valid = 1'b1;
      repeat (8) tick();
      s_valid = 1'b0;
      tick();
      repeat (40) tick();
      core_stage_done = 1'b1;
      tick();
      core_stage_done = 1'b0;
      repeat (63) tick();
      chk("wd_not_yet", 8'(err_timeout), 8'd0);
      tick();
      chk("wd_timeout", 8'(err_timeout), 8'd1);
      s_valid       = 1'b1;
      m_ready       = 1'b1;
      core_out_flag = 1'b1;
      #2;
      chk("err_s_ready", 8'(s_ready),     8'd0);
      chk("err_in_en",   8'(core_in_en),  8'd0);
      chk("err_out_en",  8'(core_out_en), 8'd0);
      chk("err_m_valid", 8'(m_valid),     8'd0);
      chk("err_start",   8'(core_start),  8'd0);
      chk("err_busy",    8'(busy),        8'd1);
      repeat (5) tick();
      chk("err_sticky", 8'(err_timeout), 8'd1);
      s_valid       = 1'b0;
      m_ready       = 1'b0;
      core_out_flag = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("err_rst_timeout", 8'(err_timeout), 8'd0);
      chk("err_rst_busy",    8'(busy),        8'd0);
      tick();
      reset = 1'b1;
      tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
